// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared UART types and constants                          |
// | Revision : 1.0                                                      |
// +----------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int CLKS_115200_100MHZ = 868;

  localparam int EVEN = 0;
  localparam int ODD  = 1;

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_sync : STAGES-flop synchroniser, resets to the idle-high level |
// | Revision  : 1.0                                                     |
// +----------------------------------------------------------------------+
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_param : parametrised UART receiver with valid/ready output  |
// | Optional parity stage enabled by macro UART_RX_PARITY_EN            |
// | Revision      : 1.0                                                 |
// +----------------------------------------------------------------------+
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_115200_100MHZ,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] C_HALF      = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] C_TERM      = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] C_LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] C_LAST_STOP = IW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || SYNC_STAGES < 2 ||
      (PARITY_ODD != EVEN && PARITY_ODD != ODD)) begin : g_bad_param
    $error("uart_rx_param: illegal parameter set");
  end

  logic                 w_rx_s;
  uart_state_t          r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_frame;
  logic                 w_term;
  logic                 w_commit;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  assign w_term   = (r_cnt == C_TERM);
  assign w_commit = (r_state == STOP) && w_term && (r_idx == C_LAST_STOP);
  assign busy     = (r_state != IDLE);

`ifdef UART_RX_PARITY_EN
  localparam logic C_PAR_INIT = (PARITY_ODD == ODD);
  logic r_par_bit;
  logic r_par_err;
  assign parity_err = r_par_err;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_frame    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit  <= 1'b0;
      r_par_err  <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (!w_rx_s) begin
            r_state <= START;
            r_frame <= 1'b0;
          end
        end
        START: begin
          if (r_cnt == C_HALF) begin
            r_cnt   <= '0;
            r_state <= w_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_term) begin
            // Shift in at the MSB so the first bit on the line ends up at the LSB.
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_cnt   <= '0;
            if (r_idx == C_LAST_BIT) begin
              r_idx <= '0;
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_term) begin
            r_par_bit <= w_rx_s;
            r_cnt     <= '0;
            r_state   <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_term) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_frame <= 1'b1;
            end
            if (r_idx == C_LAST_STOP) begin
              r_idx   <= '0;
              r_state <= IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A commit in the same cycle as a handshake keeps data_valid asserted.
      if (w_commit) begin
        data_out   <= r_shift;
        frame_err  <= r_frame | ~w_rx_s;
        data_valid <= 1'b1;
        overrun    <= data_valid & ~data_ready;
`ifdef UART_RX_PARITY_EN
        r_par_err  <= r_par_bit ^ ^r_shift ^ C_PAR_INIT;
`endif
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
